// File: rtl/turn_sequencer.sv
// Turn scheduler for the board-game controller: tracks the current player, advances on
// request or per-turn timeout, skips eliminated players and supports direction reversal.
module turn_sequencer #(
    parameter int unsigned MAX_PLAYERS = 4,
    parameter int unsigned PW          = 2,
    parameter int unsigned NW          = 3,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned TW          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NW-1:0]          num_players,
    input  logic                   advance,
    input  logic                   reverse,
    input  logic [MAX_PLAYERS-1:0] active_mask,
    output logic [PW-1:0]          turn,
    output logic                   turn_valid,
    output logic                   turn_changed,
    output logic                   round_done,
    output logic                   timeout,
    output logic                   game_over
);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    localparam logic [TW-1:0] TimerLast = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_e           state_q;
    logic             dir_q;      // 0 = forward, 1 = reverse
    logic [NW-1:0]    count_q;
    logic [TW-1:0]    timer_q;

    logic [MAX_PLAYERS-1:0] eligible;
    logic [NW-1:0]          elig_cnt;
    logic                   few_players;
    logic                   dir_next;
    logic [PW-1:0]          next_turn;
    logic                   next_found;
    logic                   wrap;
    logic                   expired;
    logic                   do_step;
    logic [NW-1:0]          count_start;

    assign turn_valid = (state_q == StPlay);

    // Eligibility of each player and how many remain in the game.
    always_comb begin
        eligible = '0;
        elig_cnt = '0;
        for (int unsigned i = 0; i < MAX_PLAYERS; i++) begin
            eligible[i] = active_mask[i] && (32'(count_q) > i);
            elig_cnt    = elig_cnt + NW'(eligible[i]);
        end
    end

    assign few_players = (elig_cnt < NW'(2));

    // A reverse in the same cycle as a step applies before the step.
    assign dir_next = dir_q ^ reverse;

    // Walk away from the current turn modulo count; the first eligible index wins.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        next_turn  = turn;
        next_found = 1'b0;
        for (int unsigned k = 1; k < MAX_PLAYERS; k++) begin
            if (!next_found && (k < 32'(count_q))) begin
                if (!dir_next) begin
                    idx = 32'(turn) + k;
                end else begin
                    idx = 32'(turn) + 32'(count_q) - k;
                end
                if (idx >= 32'(count_q)) begin
                    idx = idx - 32'(count_q);
                end
                if (eligible[PW'(idx)]) begin
                    next_turn  = PW'(idx);
                    next_found = 1'b1;
                end
            end
        end
    end

    // Wrapping past index 0 in the direction of travel closes a round.
    assign wrap = dir_next ? (next_turn > turn) : (next_turn < turn);

    assign expired = (TIMEOUT_CYC != 0) && (timer_q == TimerLast);
    assign do_step = advance || expired;

    // Player count latched on start, clamped to the supported range.
    always_comb begin
        count_start = num_players;
        if (num_players < NW'(2)) begin
            count_start = NW'(2);
        end else if (32'(num_players) > MAX_PLAYERS) begin
            count_start = NW'(MAX_PLAYERS);
        end
    end

    // Game FSM with registered turn state and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            turn         <= '0;
            dir_q        <= 1'b0;
            count_q      <= NW'(2);
            timer_q      <= '0;
            turn_changed <= 1'b0;
            round_done   <= 1'b0;
            timeout      <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            turn_changed <= 1'b0;
            round_done   <= 1'b0;
            timeout      <= 1'b0;
            if (start) begin
                state_q      <= StPlay;
                count_q      <= count_start;
                turn         <= '0;
                dir_q        <= 1'b0;
                timer_q      <= '0;
                turn_changed <= 1'b1;
                game_over    <= 1'b0;
            end else begin
                case (state_q)
                    StPlay: begin
                        if (few_players || (do_step && !next_found)) begin
                            state_q   <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            dir_q <= dir_next;
                            if (do_step) begin
                                turn         <= next_turn;
                                turn_changed <= 1'b1;
                                round_done   <= wrap;
                                // Only an expiry without a coincident request counts as timeout.
                                timeout      <= !advance;
                                timer_q      <= '0;
                            end else if (TIMEOUT_CYC != 0) begin
                                timer_q <= timer_q + TW'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: stimulus pushes expected events, a monitor checks them.
module tb_turn_sequencer;

    localparam int unsigned MAXP = 4;
    localparam int unsigned PW   = 2;
    localparam int unsigned NW   = 3;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NW-1:0]   num_players = '0;
    logic            advance = 1'b0;
    logic            reverse = 1'b0;
    logic [MAXP-1:0] active_mask = 4'b1111;
    logic [PW-1:0]   turn;
    logic            turn_valid;
    logic            turn_changed;
    logic            round_done;
    logic            timeout;
    logic            game_over;

    turn_sequencer #(
        .MAX_PLAYERS(MAXP),
        .PW(PW),
        .NW(NW),
        .TIMEOUT_CYC(TO),
        .TW(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_players(num_players),
        .advance(advance),
        .reverse(reverse),
        .active_mask(active_mask),
        .turn(turn),
        .turn_valid(turn_valid),
        .turn_changed(turn_changed),
        .round_done(round_done),
        .timeout(timeout),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         over;
        logic [1:0] turn;
        bit         rd;
        bit         to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic go_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_turn(input logic [1:0] t, input bit rd, input bit to);
        exp_q.push_back('{over: 1'b0, turn: t, rd: rd, to: to});
    endtask

    task automatic expect_over(input logic [1:0] t);
        exp_q.push_back('{over: 1'b1, turn: t, rd: 1'b0, to: 1'b0});
    endtask

    task automatic do_start(input logic [NW-1:0] n);
        num_players = n;
        start = 1'b1;
        expect_turn(2'd0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
    endtask

    task automatic do_adv(input logic [1:0] t, input bit rd, input bit to);
        advance = 1'b1;
        expect_turn(t, rd, to);
        tick();
        advance = 1'b0;
    endtask

    task automatic handle(input bit is_over);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d turn %0d expected none", is_over, turn);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_over), 32'(e.over));
            check("event_turn", 32'(turn), 32'(e.turn));
            if (!is_over) begin
                check("round_done", 32'(round_done), 32'(e.rd));
                check("timeout", 32'(timeout), 32'(e.to));
                check("turn_valid_play", 32'(turn_valid), 32'd1);
            end else begin
                check("turn_valid_over", 32'(turn_valid), 32'd0);
            end
        end
    endtask

    // Monitor: every turn_changed pulse and every rise of game_over is an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (turn_changed) handle(1'b0);
            if (game_over && !go_prev) handle(1'b1);
        end
        go_prev = game_over;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_turn_valid", 32'(turn_valid), 32'd0);
        check("rst_turn_changed", 32'(turn_changed), 32'd0);
        check("rst_round_done", 32'(round_done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three players, forward rotation
        do_start(3'd3);
        do_adv(2'd1, 1'b0, 1'b0);
        do_adv(2'd2, 1'b0, 1'b0);
        do_adv(2'd0, 1'b1, 1'b0);
        do_adv(2'd1, 1'b0, 1'b0);
        tick();
        check("t1_turn_valid", 32'(turn_valid), 32'd1);

        // Reverse together with advance uses the new direction
        do_start(3'd4);
        do_adv(2'd1, 1'b0, 1'b0);
        reverse = 1'b1;
        do_adv(2'd0, 1'b0, 1'b0);
        reverse = 1'b0;
        do_adv(2'd3, 1'b1, 1'b0);
        tick();

        // Skip eliminated player, then game over when one player remains
        active_mask = 4'b1011;
        do_start(3'd4);
        do_adv(2'd1, 1'b0, 1'b0);
        do_adv(2'd3, 1'b0, 1'b0);
        active_mask = 4'b0001;
        expect_over(2'd3);
        tick();
        tick();
        check("t3_game_over", 32'(game_over), 32'd1);
        check("t3_turn_valid", 32'(turn_valid), 32'd0);
        check("t3_turn_hold", 32'(turn), 32'd3);
        advance = 1'b1;
        reverse = 1'b1;
        tick();
        advance = 1'b0;
        reverse = 1'b0;
        tick();
        check("t3_over_ignores_adv", 32'(turn), 32'd3);
        check("t3_over_level", 32'(game_over), 32'd1);

        // Timeout auto-advance, then advance coincident with expiry
        active_mask = 4'b1111;
        do_start(3'd4);
        expect_turn(2'd1, 1'b0, 1'b1);
        repeat (10) tick();
        do_start(3'd4);
        repeat (7) tick();
        do_adv(2'd1, 1'b0, 1'b0);
        tick();

        // Count clamping and start during PLAY resets direction
        do_start(3'd0);
        do_adv(2'd1, 1'b0, 1'b0);
        do_adv(2'd0, 1'b1, 1'b0);
        do_adv(2'd1, 1'b0, 1'b0);
        reverse = 1'b1;
        tick();
        reverse = 1'b0;
        do_start(3'd7);
        do_adv(2'd1, 1'b0, 1'b0);
        do_adv(2'd2, 1'b0, 1'b0);
        do_adv(2'd3, 1'b0, 1'b0);
        do_adv(2'd0, 1'b1, 1'b0);
        do_adv(2'd1, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-game
        rst_n = 1'b0;
        #1;
        check("t6_rst_turn", 32'(turn), 32'd0);
        check("t6_rst_turn_valid", 32'(turn_valid), 32'd0);
        check("t6_rst_turn_changed", 32'(turn_changed), 32'd0);
        check("t6_rst_game_over", 32'(game_over), 32'd0);
        tick();
        rst_n = 1'b1;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        tick();
        check("t6_idle_turn", 32'(turn), 32'd0);
        check("t6_idle_turn_valid", 32'(turn_valid), 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
